// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: FSM encoding and the
// packed layout of each stage boundary's control/data bundles.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam int WORD_W  = 32;
  localparam int RDEST_W = 5;

  // IF/ID: PC and IR, plus a predicted-taken and a fetch-fault bit
  localparam int IFID_CTRL_W  = 2;
  localparam int IFID_DATA_W  = 2 * WORD_W;
  localparam int IFID_IR_LSB  = 0;
  localparam int IFID_PC_LSB  = WORD_W;

  // ID/EX: IR, A, B, sign-extended immediate
  localparam int IDEX_CTRL_W  = 13;
  localparam int IDEX_DATA_W  = 4 * WORD_W;
  localparam int IDEX_IMM_LSB = 0;
  localparam int IDEX_B_LSB   = WORD_W;
  localparam int IDEX_A_LSB   = 2 * WORD_W;
  localparam int IDEX_IR_LSB  = 3 * WORD_W;

  // EX/MEM and MEM/WB share one layout: {IR, B, Result, RegDest}
  localparam int EXMEM_CTRL_W = 13;
  localparam int EXMEM_DATA_W = 3 * WORD_W + RDEST_W;
  localparam int MEMWB_CTRL_W = 13;
  localparam int MEMWB_DATA_W = 3 * WORD_W + RDEST_W;

  localparam int WB_RDEST_LSB  = 0;
  localparam int WB_RESULT_LSB = RDEST_W;
  localparam int WB_B_LSB      = RDEST_W + WORD_W;
  localparam int WB_IR_LSB     = RDEST_W + 2 * WORD_W;

  typedef struct packed {
    logic [WORD_W-1:0]  ir;
    logic [WORD_W-1:0]  b;
    logic [WORD_W-1:0]  result;
    logic [RDEST_W-1:0] rdest;
  } memwb_data_t;

  function automatic logic [MEMWB_DATA_W-1:0] memwb_pack(
    input logic [WORD_W-1:0]  ir,
    input logic [WORD_W-1:0]  b,
    input logic [WORD_W-1:0]  result,
    input logic [RDEST_W-1:0] rdest
  );
    memwb_data_t d;
    d.ir     = ir;
    d.b      = b;
    d.result = result;
    d.rdest  = rdest;
    return d;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && cnt_q != CNT_MAX)
      cnt_d = cnt_q + CNT_ONE;
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with optional 2-entry skid buffer, flush
// (bubble insertion) and a saturating downstream-stall counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 13,
  parameter int DATA_W = 101,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              clr_cnt
);

  state_e            state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_ready_q, in_ready_d;
  logic              in_fire, out_fire;

  // Outputs come straight from the main register; ctrl is gated so a bubble
  // can never raise a downstream write enable.
  assign out_valid = (state_q != ST_EMPTY);
  assign out_ctrl  = out_valid ? main_ctrl_q : '0;
  assign out_data  = main_data_q;

  assign in_ready  = (SKID != 0) ? in_ready_q : (!out_valid || out_ready);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d     = ST_ONE;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (in_fire && SKID != 0) begin
            // Without a skid buffer in_fire here implies out_fire, so the
            // skid registers stay constant and drop out of the netlist.
            state_d     = ST_FULL;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_d     = ST_ONE;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    in_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      in_ready_q  <= in_ready_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (out_valid && !out_ready),
    .clr   (clr_cnt),
    .cnt   (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid instance (CNT_W=4) and a no-skid instance
// share stimulus and are both tracked by a FIFO-occupancy reference model.
module tb_pipe_stage_reg;

  localparam int CW = 13;
  localparam int DW = 101;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset = 1'b1, flush = 1'b0, clr_cnt = 1'b0;
  logic          in_valid = 1'b0, out_ready = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;

  logic          a_in_ready, a_out_valid;
  logic [CW-1:0] a_out_ctrl;
  logic [DW-1:0] a_out_data;
  logic [3:0]    a_stall;
  logic          b_in_ready, b_out_valid;
  logic [CW-1:0] b_out_ctrl;
  logic [DW-1:0] b_out_data;
  logic [15:0]   b_stall;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(4)) u_a (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_ctrl(a_out_ctrl),
    .out_data(a_out_data), .stall_cnt(a_stall), .clr_cnt(clr_cnt)
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(16)) u_b (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_ctrl(b_out_ctrl),
    .out_data(b_out_data), .stall_cnt(b_stall), .clr_cnt(clr_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: each instance is a FIFO of capacity 2 (skid) or 1.
  logic [CW-1:0] m_ctrl [2][2];
  logic [DW-1:0] m_data [2][2];
  logic [DW-1:0] m_last [2];
  int            m_n    [2];
  int            m_cnt  [2];
  int            m_cmax [2] = '{15, 65535};
  bit            m_skid [2] = '{1'b1, 1'b0};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit model_ready(input int k);
    return m_skid[k] ? (m_n[k] < 2) : (m_n[k] == 0 || out_ready);
  endfunction

  task automatic model_step(input int k);
    bit ov, rdy;
    ov  = m_n[k] > 0;
    rdy = model_ready(k);
    if (reset) begin
      m_n[k] = 0; m_last[k] = '0; m_cnt[k] = 0;
      return;
    end
    if (clr_cnt) m_cnt[k] = 0;
    else if (ov && !out_ready && m_cnt[k] < m_cmax[k]) m_cnt[k]++;
    if (flush) begin
      m_n[k] = 0;
    end else begin
      if (ov && out_ready) begin
        m_ctrl[k][0] = m_ctrl[k][1];
        m_data[k][0] = m_data[k][1];
        m_n[k]--;
      end
      if (in_valid && rdy) begin
        m_ctrl[k][m_n[k]] = in_ctrl;
        m_data[k][m_n[k]] = in_data;
        m_n[k]++;
      end
      if (m_n[k] > 0) m_last[k] = m_data[k][0];
    end
  endtask

  task automatic check_outs();
    chk("a out_valid", 128'(a_out_valid), 128'(m_n[0] > 0));
    chk("a out_ctrl",  128'(a_out_ctrl),  128'((m_n[0] > 0) ? m_ctrl[0][0] : 13'd0));
    chk("a out_data",  128'(a_out_data),  128'(m_last[0]));
    chk("a stall_cnt", 128'(a_stall),     128'(m_cnt[0]));
    chk("b out_valid", 128'(b_out_valid), 128'(m_n[1] > 0));
    chk("b out_ctrl",  128'(b_out_ctrl),  128'((m_n[1] > 0) ? m_ctrl[1][0] : 13'd0));
    chk("b out_data",  128'(b_out_data),  128'(m_last[1]));
    chk("b stall_cnt", 128'(b_stall),     128'(m_cnt[1]));
  endtask

  // Called just after inputs change at a negedge; returns at the next negedge.
  task automatic cycle();
    #1;
    if (!reset) begin
      chk("a in_ready", 128'(a_in_ready), 128'(model_ready(0)));
      chk("b in_ready", 128'(b_in_ready), 128'(model_ready(1)));
    end
    model_step(0);
    model_step(1);
    @(posedge clock);
    @(negedge clock);
    check_outs();
  endtask

  typedef struct {
    bit            rst, fl, clr, iv, orr;
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
    bit            e_ov;
    logic [CW-1:0] e_oc;
    logic [DW-1:0] e_od;
    bit            e_ir;
    logic [3:0]    e_st;
  } vec_t;

  function automatic logic [CW-1:0] cw(input int d);
    return 13'h100 + CW'(d);
  endfunction

  function automatic vec_t mkv(input bit rst, input bit fl, input bit clr, input bit iv,
                               input logic [CW-1:0] ctrl, input int d, input bit orr,
                               input bit eov, input int eod, input bit eir, input int est);
    vec_t v;
    v.rst = rst; v.fl = fl; v.clr = clr; v.iv = iv; v.orr = orr;
    v.ctrl = ctrl; v.data = DW'(d);
    v.e_ov = eov; v.e_od = DW'(eod); v.e_ir = eir; v.e_st = 4'(est);
    v.e_oc = eov ? cw(eod) : 13'd0;
    return v;
  endfunction

  vec_t tbl [23];

  task automatic drive(input bit rst, input bit fl, input bit clr, input bit iv,
                       input logic [CW-1:0] ctrl, input logic [DW-1:0] d, input bit orr);
    reset = rst; flush = fl; clr_cnt = clr; in_valid = iv;
    in_ctrl = ctrl; in_data = d; out_ready = orr;
  endtask

  initial begin
    logic [127:0] r;
    m_n = '{0, 0}; m_cnt = '{0, 0}; m_last = '{'0, '0};

    // reset, stream 1..5
    tbl[0] = mkv(1,0,0,0,13'd0,0,0, 0,0,1,0);
    for (int i = 1; i <= 5; i++) tbl[i] = mkv(0,0,0,1,cw(i),i,1, 1,i,1,0);
    tbl[6]  = mkv(0,0,0,0,13'd0,0,1, 0,5,1,0);
    // backpressure into FULL and release
    tbl[7]  = mkv(0,0,0,1,cw(1),1,1, 1,1,1,0);
    tbl[8]  = mkv(0,0,0,1,cw(2),2,1, 1,2,1,0);
    tbl[9]  = mkv(0,0,0,1,cw(3),3,0, 1,2,0,1);
    tbl[10] = mkv(0,0,0,1,cw(4),4,0, 1,2,0,2);
    tbl[11] = mkv(0,0,0,1,cw(4),4,0, 1,2,0,3);
    tbl[12] = mkv(0,0,0,1,cw(4),4,1, 1,3,1,3);
    tbl[13] = mkv(0,0,0,1,cw(4),4,1, 1,4,1,3);
    tbl[14] = mkv(0,0,0,0,13'd0,0,1, 0,4,1,3);
    // fill to FULL then flush with a live input of 9
    tbl[15] = mkv(0,0,0,1,cw(5),5,0, 1,5,1,3);
    tbl[16] = mkv(0,0,0,1,cw(6),6,0, 1,5,0,4);
    tbl[17] = mkv(0,1,0,1,cw(9),9,0, 0,5,1,5);
    tbl[18] = mkv(0,0,0,0,13'd0,0,1, 0,5,1,5);
    // bubbles carrying all-ones ctrl
    for (int i = 19; i <= 21; i++) tbl[i] = mkv(0,0,0,0,13'h1FFF,0,1, 0,5,1,5);
    tbl[22] = mkv(0,0,1,0,13'd0,0,1, 0,5,1,0);

    @(negedge clock);
    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].rst, tbl[i].fl, tbl[i].clr, tbl[i].iv, tbl[i].ctrl, tbl[i].data, tbl[i].orr);
      cycle();
      chk($sformatf("vec%0d out_valid", i), 128'(a_out_valid), 128'(tbl[i].e_ov));
      chk($sformatf("vec%0d out_ctrl", i),  128'(a_out_ctrl),  128'(tbl[i].e_oc));
      chk($sformatf("vec%0d out_data", i),  128'(a_out_data),  128'(tbl[i].e_od));
      chk($sformatf("vec%0d in_ready", i),  128'(a_in_ready),  128'(tbl[i].e_ir));
      chk($sformatf("vec%0d stall_cnt", i), 128'(a_stall),     128'(tbl[i].e_st));
    end

    // no-skid instance: combinational in_ready and pass-through
    drive(1,0,0,0,'0,'0,0); cycle();
    drive(0,0,0,1,cw(7),DW'(7),1); cycle();
    chk("s0 first out", 128'(b_out_data), 128'(7));
    drive(0,0,0,1,cw(8),DW'(8),0); #1;
    chk("s0 in_ready blocked", 128'(b_in_ready), 128'(0));
    cycle();
    chk("s0 held out", 128'(b_out_data), 128'(7));
    for (int d = 8; d <= 11; d++) begin
      drive(0,0,0,1,cw(d),DW'(d),1); #1;
      chk("s0 in_ready open", 128'(b_in_ready), 128'(1));
      cycle();
      chk("s0 pass-through", 128'(b_out_data), 128'(d));
      chk("s0 valid", 128'(b_out_valid), 128'(1));
    end

    // stall counter saturation and clear-while-stalling
    drive(1,0,0,0,'0,'0,0); cycle();
    drive(0,0,0,1,cw(1),DW'(1),0); cycle();
    drive(0,0,0,0,'0,'0,0);
    for (int i = 0; i < 20; i++) cycle();
    chk("sat stall_cnt", 128'(a_stall), 128'(15));
    drive(0,0,1,0,'0,'0,0); cycle();
    chk("clr stall_cnt", 128'(a_stall), 128'(0));
    drive(0,0,0,0,'0,'0,0); cycle();
    chk("after clr stall_cnt", 128'(a_stall), 128'(1));

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 31) == 0,
            $urandom_range(0, 31) == 0, $urandom_range(0, 9) < 7,
            CW'($urandom), r[DW-1:0], $urandom_range(0, 9) < 6);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
